ps2_device_tx: RTL

PS2_DEVICE_TX -- requirements
Module: ps2_device_tx

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_sync.sv | 25 ++
 rtl/ps2_device_tx.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 device definitions: FSM states, reply bytes, frame length
// and the frame/parity helpers used by the device-side transceiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLDOFF,
    ST_TX,
    ST_INHIBIT,
    ST_RX,
    ST_RX_ACK,
    ST_ACK_Q
  } ps2_state_e;

  localparam logic [7:0] PS2_ACK       = 8'hFA;
  localparam logic [7:0] PS2_RESEND    = 8'hFE;
  localparam int         PS2_FRAME_LEN = 11;

  // Bit that makes the 8 data bits plus parity contain an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Bit 0 is the start bit, bit 10 the stop bit.
  function automatic logic [PS2_FRAME_LEN-1:0] ps2_frame(input logic [7:0] d);
    return {1'b1, odd_parity(d), d, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for one open-collector PS/2 line; resets to the
// released (high) level so the bus looks idle straight out of reset.
module ps2_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transceiver: sends scan-code bytes, receives host
// commands (with ack pulse) and optionally auto-replies 0xFA / 0xFE.
module ps2_device_tx
  import ps2_pkg::*;
#(
  parameter int HALF_PER = 4,
  parameter int IDLE_MIN = 8,
  parameter bit AUTO_ACK = 1'b1
) (
  input  logic       i_clk_100k,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_dat_oe,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_rx_err,
  output logic       o_busy
);

  localparam logic [15:0] HALF_LAST = 16'(HALF_PER - 1);
  localparam logic [15:0] IDLE_LAST = 16'(IDLE_MIN - 1);
  localparam logic [3:0]  STOP_IDX  = 4'(PS2_FRAME_LEN - 1);
  localparam logic [3:0]  RX_STOP   = 4'(PS2_FRAME_LEN - 2);

  logic sclk, sdat;

  ps2_sync u_sync_clk (.i_clk(i_clk_100k), .i_rst(i_rst), .i_d(i_ps2_clk), .o_q(sclk));
  ps2_sync u_sync_dat (.i_clk(i_clk_100k), .i_rst(i_rst), .i_d(i_ps2_dat), .o_q(sdat));

  ps2_state_e        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [3:0]        bit_q, bit_d;
  logic              phase_q, phase_d;   // 0 = clock released, 1 = clock pulled low
  logic [10:0]       tx_frame_q, tx_frame_d;
  logic              tx_is_ack_q, tx_is_ack_d;
  logic [7:0]        user_byte_q, user_byte_d;
  logic              user_pend_q, user_pend_d;
  logic [7:0]        ack_byte_q, ack_byte_d;
  logic              ack_pend_q, ack_pend_d;
  logic [8:0]        rx_shift_q, rx_shift_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_err_q, rx_err_d;
  logic              tx_ready_q, tx_ready_d;
  logic              busy_q, busy_d;
  logic              clk_oe_q, clk_oe_d;
  logic              dat_oe_q, dat_oe_d;

  logic host_rts, line_idle, half_done;

  assign host_rts  = sclk & ~sdat;
  assign line_idle = sclk & sdat;
  assign half_done = (cnt_q == HALF_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    phase_d     = phase_q;
    tx_frame_d  = tx_frame_q;
    tx_is_ack_d = tx_is_ack_q;
    user_byte_d = user_byte_q;
    user_pend_d = user_pend_q;
    ack_byte_d  = ack_byte_q;
    ack_pend_d  = ack_pend_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        bit_d   = '0;
        phase_d = 1'b0;
        if (tx_ready_q && i_tx_valid) begin
          user_byte_d = i_tx_data;
          user_pend_d = 1'b1;
        end
        if (host_rts) begin
          state_d = ST_RX;
          phase_d = 1'b1;
        end else if (user_pend_q || ack_pend_q) begin
          state_d = ST_HOLDOFF;
        end
      end

      ST_HOLDOFF: begin
        if (host_rts) begin
          state_d = ST_RX;
          cnt_d   = '0;
          bit_d   = '0;
          phase_d = 1'b1;
        end else if (!line_idle) begin
          cnt_d = '0;
        end else if (cnt_q == IDLE_LAST) begin
          // A queued ack reply always goes ahead of the user byte.
          state_d     = ST_TX;
          cnt_d       = '0;
          bit_d       = '0;
          phase_d     = 1'b0;
          tx_is_ack_d = ack_pend_q;
          tx_frame_d  = ps2_frame(ack_pend_q ? ack_byte_q : user_byte_q);
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_TX: begin
        if (!half_done) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d = '0;
          if (!phase_q) begin
            // Host holding the clock low while we release it; ignored on the stop pulse.
            if (!sclk && bit_q != STOP_IDX) begin
              state_d = ST_INHIBIT;
            end else begin
              phase_d = 1'b1;
            end
          end else if (bit_q == STOP_IDX) begin
            state_d = ST_IDLE;
            if (tx_is_ack_q) ack_pend_d = 1'b0;
            else             user_pend_d = 1'b0;
          end else begin
            bit_d   = bit_q + 4'd1;
            phase_d = 1'b0;
          end
        end
      end

      ST_INHIBIT: begin
        // Short guard lets the synchronizers settle after both lines are released.
        if (cnt_q < 16'd2) begin
          cnt_d = cnt_q + 16'd1;
        end else if (sclk) begin
          state_d = ST_IDLE;
        end
      end

      ST_RX: begin
        if (!half_done) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d = '0;
          if (phase_q) begin
            phase_d = 1'b0;
          end else if (bit_q == RX_STOP) begin
            if (sdat) begin
              state_d = ST_RX_ACK;
            end else begin
              state_d  = ST_IDLE;
              rx_err_d = 1'b1;
            end
          end else begin
            rx_shift_d = {sdat, rx_shift_q[8:1]};
            bit_d      = bit_q + 4'd1;
            phase_d    = 1'b1;
          end
        end
      end

      ST_RX_ACK: begin
        if (!half_done) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d = '0;
          if (!phase_q) phase_d = 1'b1;
          else          state_d = ST_ACK_Q;
        end
      end

      ST_ACK_Q: begin
        state_d = ST_IDLE;
        if (odd_parity(rx_shift_q[7:0]) == rx_shift_q[8]) begin
          rx_data_d  = rx_shift_q[7:0];
          rx_valid_d = 1'b1;
          ack_byte_d = PS2_ACK;
        end else begin
          rx_err_d   = 1'b1;
          ack_byte_d = PS2_RESEND;
        end
        ack_pend_d = AUTO_ACK ? 1'b1 : ack_pend_q;
      end

      default: state_d = ST_IDLE;
    endcase

    tx_ready_d = (state_d == ST_IDLE) && !user_pend_d;
    busy_d     = (state_d != ST_IDLE);
    clk_oe_d   = phase_d && (state_d == ST_TX || state_d == ST_RX || state_d == ST_RX_ACK);
    dat_oe_d   = (state_d == ST_TX) ? ~tx_frame_d[bit_d] : (state_d == ST_RX_ACK);
  end

  always_ff @(posedge i_clk_100k) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      phase_q     <= 1'b0;
      tx_frame_q  <= '0;
      tx_is_ack_q <= 1'b0;
      user_byte_q <= '0;
      user_pend_q <= 1'b0;
      ack_byte_q  <= '0;
      ack_pend_q  <= 1'b0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_err_q    <= 1'b0;
      tx_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      clk_oe_q    <= 1'b0;
      dat_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      phase_q     <= phase_d;
      tx_frame_q  <= tx_frame_d;
      tx_is_ack_q <= tx_is_ack_d;
      user_byte_q <= user_byte_d;
      user_pend_q <= user_pend_d;
      ack_byte_q  <= ack_byte_d;
      ack_pend_q  <= ack_pend_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_err_q    <= rx_err_d;
      tx_ready_q  <= tx_ready_d;
      busy_q      <= busy_d;
      clk_oe_q    <= clk_oe_d;
      dat_oe_q    <= dat_oe_d;
    end
  end

  assign o_ps2_clk_oe = clk_oe_q;
  assign o_ps2_dat_oe = dat_oe_q;
  assign o_tx_ready   = tx_ready_q;
  assign o_rx_data    = rx_data_q;
  assign o_rx_valid   = rx_valid_q;
  assign o_rx_err     = rx_err_q;
  assign o_busy       = busy_q;

endmodule
